// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one SPI_Master between two requesters, one 16-bit word per grant
//   Clk, rst                  : system clock, asynchronous active-high reset
//   en                        : 1 allows new grants; an in-flight transaction always completes
//   req0/1, wdata0/1, cs_pol0/1 : requests, held stable until the matching ack
//   ack0/1                    : one-cycle pulse, request accepted and inputs captured
//   done0/1                   : one-cycle pulse, rdata/err valid for that requester
//   rdata, err                : received word and timeout flag, hold until the next done
//   busy                      : any state other than IDLE
//   spi_start, spi_tx_data, spi_cs_pol : drive the master's start pulse, TX word and cs polarity
//   spi_rx_dv, spi_rx_data    : master's RX-valid pulse and received word
module spi_txn_arbiter #(
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic        en,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    input  logic        cs_pol0,
    input  logic        cs_pol1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        spi_start,
    output logic [15:0] spi_tx_data,
    output logic        spi_cs_pol,
    input  logic        spi_rx_dv,
    input  logic [15:0] spi_rx_data
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_RX, GAP} state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          done0_q, done0_d, done1_q, done1_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          start_q, start_d;
    logic [15:0]   tx_q, tx_d;
    logic          pol_q, pol_d;
    logic          pick;

    always_comb begin
        // a tie goes to whoever was not granted last
        pick    = (req0 && req1) ? ~last_q : req1;
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        start_d = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        tx_d    = tx_q;
        pol_d   = pol_q;
        case (state_q)
            IDLE: if (en && (req0 || req1)) begin
                state_d = LAUNCH;
                gnt_d   = pick;
                last_d  = pick;
                ack0_d  = ~pick;
                ack1_d  = pick;
                start_d = 1'b1;
                tx_d    = pick ? wdata1 : wdata0;
                pol_d   = pick ? cs_pol1 : cs_pol0;
            end
            LAUNCH: begin
                state_d = WAIT_RX;
                tcnt_d  = '0;
            end
            // a response arriving on the final timeout cycle still counts as success
            WAIT_RX: if (spi_rx_dv || tcnt_q == T_LAST) begin
                state_d = GAP;
                gcnt_d  = '0;
                done0_d = ~gnt_q;
                done1_d = gnt_q;
                rdata_d = spi_rx_dv ? spi_rx_data : 16'h0;
                err_d   = ~spi_rx_dv;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
            GAP: if (gcnt_q == G_LAST) state_d = IDLE;
                 else gcnt_d = gcnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rdata_q <= 16'h0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            tx_q    <= 16'h0;
            pol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            tx_q    <= tx_d;
            pol_q   <= pol_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign rdata       = rdata_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign spi_start   = start_q;
    assign spi_tx_data = tx_q;
    assign spi_cs_pol  = pol_q;
endmodule
